// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, command bytes
// and the default end-of-program marker.
package program_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  localparam logic [7:0]  CMD_LOAD           = 8'h4C;
  localparam logic [7:0]  CMD_RUN            = 8'h52;
  localparam logic [7:0]  CMD_STEP           = 8'h53;
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in bits 7:0.
// word_ready strobes in the cycle of the last byte, with word carrying the complete value.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter int NB_INSTR = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                clear,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                word_ready,
  output logic [NB_INSTR-1:0] word
);

  localparam int NB_BYTES = NB_INSTR / 8;
  localparam int NB_CNT   = $clog2(NB_BYTES);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);

  logic [NB_CNT-1:0]   byte_cnt_r;
  logic [NB_INSTR-1:0] shift_r;

  // New bytes enter at the top so that after a full word the first byte sits at the bottom.
  assign word       = {byte_data, shift_r[NB_INSTR-1:8]};
  assign word_ready = byte_valid & (byte_cnt_r == LAST_BYTE);

  // Byte counter and shift register; the counter wraps naturally after the last byte.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      byte_cnt_r <= '0;
      shift_r    <= '0;
    end else if (clear) begin
      byte_cnt_r <= '0;
      shift_r    <= '0;
    end else if (byte_valid) begin
      byte_cnt_r <= byte_cnt_r + NB_CNT'(1);
      shift_r    <= word;
    end else begin
      byte_cnt_r <= byte_cnt_r;
      shift_r    <= shift_r;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: loads a byte stream into instruction memory, then runs the CPU.
// Single-step mode (STEP state, command 0x53) exists only when PROGRAM_LOADER_STEP_EN is defined.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                  NB_INSTR    = 32,
  parameter int                  NB_DBG_ADDR = 16,
  parameter int                  N_ADDR      = 2048,
  parameter logic [NB_INSTR-1:0] HALT_INSTR  = HALT_INSTR_DEFAULT
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  input  logic                   i_cpu_halt,
  output logic [NB_DBG_ADDR-1:0] o_instrmem_addr,
  output logic [NB_INSTR-1:0]    o_instrmem_data,
  output logic [3:0]             o_instrmem_we,
  output logic                   o_cpu_valid,
  output logic                   o_cpu_reset,
  output logic                   o_load_done,
  output logic                   o_run_done,
  output logic                   o_overflow,
  output logic [NB_DBG_ADDR-1:0] o_word_count
);

  state_t                 state_r;
  logic [NB_DBG_ADDR-1:0] word_cnt_r;
  logic                   cpu_valid_r;
  logic                   asm_clear_s;
  logic                   asm_valid_s;
  logic                   word_ready_s;
  logic [NB_INSTR-1:0]    word_s;
  logic                   is_halt_s;
  logic                   is_last_s;
  logic                   running_s;

  assign asm_clear_s  = (state_r == ST_IDLE) & i_rx_valid & (i_rx_data == CMD_LOAD);
  assign asm_valid_s  = (state_r == ST_LOAD) & i_rx_valid;
  assign is_halt_s    = (word_s == HALT_INSTR);
  assign is_last_s    = (word_cnt_r == NB_DBG_ADDR'(N_ADDR - 1));
  assign o_word_count = word_cnt_r;

`ifdef PROGRAM_LOADER_STEP_EN
  assign running_s = (state_r == ST_RUN) | (state_r == ST_STEP);
`else
  assign running_s = (state_r == ST_RUN);
`endif

  // A halt retires in the same cycle it is seen, so it masks the advance enable immediately.
  assign o_cpu_valid = cpu_valid_r & ~i_cpu_halt;
  assign o_run_done  = running_s & i_cpu_halt;

  word_assembler #(
    .NB_INSTR (NB_INSTR)
  ) u_word_assembler (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .clear      (asm_clear_s),
    .byte_valid (asm_valid_s),
    .byte_data  (i_rx_data),
    .word_ready (word_ready_s),
    .word       (word_s)
  );

  // Control FSM with registered memory-port and status outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r         <= ST_IDLE;
      word_cnt_r      <= '0;
      cpu_valid_r     <= 1'b0;
      o_cpu_reset     <= 1'b1;
      o_instrmem_we   <= 4'h0;
      o_instrmem_addr <= '0;
      o_instrmem_data <= '0;
      o_load_done     <= 1'b0;
      o_overflow      <= 1'b0;
    end else begin
      o_instrmem_we <= 4'h0;
      o_load_done   <= 1'b0;
      cpu_valid_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          o_cpu_reset <= 1'b0;
          if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
            state_r     <= ST_LOAD;
            word_cnt_r  <= '0;
            o_overflow  <= 1'b0;
            o_cpu_reset <= 1'b1;
          end else if (i_rx_valid && (i_rx_data == CMD_RUN)) begin
            state_r     <= ST_RUN;
            cpu_valid_r <= 1'b1;
`ifdef PROGRAM_LOADER_STEP_EN
          end else if (i_rx_valid && (i_rx_data == CMD_STEP)) begin
            state_r     <= ST_STEP;
            cpu_valid_r <= 1'b1;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          o_cpu_reset <= 1'b1;
          if (o_load_done) begin
            // The write cycle that ended the load has passed; release the CPU.
            state_r     <= ST_IDLE;
            o_cpu_reset <= 1'b0;
          end else if (word_ready_s) begin
            o_instrmem_we   <= 4'hF;
            o_instrmem_addr <= word_cnt_r;
            o_instrmem_data <= word_s;
            word_cnt_r      <= word_cnt_r + NB_DBG_ADDR'(1);
            if (is_halt_s) begin
              o_load_done <= 1'b1;
            end else if (is_last_s) begin
              o_load_done <= 1'b1;
              o_overflow  <= 1'b1;
            end else begin
              o_load_done <= 1'b0;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_RUN: begin
          o_cpu_reset <= 1'b0;
          if (i_cpu_halt) begin
            state_r <= ST_IDLE;
          end else begin
            cpu_valid_r <= 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_STEP_EN
        ST_STEP: begin
          o_cpu_reset <= 1'b0;
          if (i_cpu_halt) begin
            state_r <= ST_IDLE;
          end else if (i_rx_valid && (i_rx_data == CMD_STEP)) begin
            cpu_valid_r <= 1'b1;
          end else if (i_rx_valid && (i_rx_data == CMD_RUN)) begin
            state_r     <= ST_RUN;
            cpu_valid_r <= 1'b1;
          end else if (i_rx_valid) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_STEP;
          end
        end
`endif
        default: begin
          state_r     <= ST_IDLE;
          o_cpu_reset <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued at stimulus time
// and popped by negedge monitors; a second instance with N_ADDR=4 covers overflow.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [7:0]  rx_data, rx_data_ovf;
  logic        rx_valid, rx_valid_ovf;
  logic        cpu_halt, cpu_halt_ovf;

  logic [15:0] mem_addr, mem_addr_ovf;
  logic [31:0] mem_data, mem_data_ovf;
  logic [3:0]  mem_we, mem_we_ovf;
  logic        cpu_valid, cpu_valid_ovf;
  logic        cpu_reset, cpu_reset_ovf;
  logic        load_done, load_done_ovf;
  logic        run_done, run_done_ovf;
  logic        overflow, overflow_ovf;
  logic [15:0] word_count, word_count_ovf;

  int n_vec = 0;
  int n_err = 0;
  int load_done_cnt = 0, run_done_cnt = 0, valid_cnt = 0, load_done_ovf_cnt = 0;
  int ld0, rd0, v0;

  wr_t        exp_q[$];
  wr_t        exp_ovf_q[$];
  wr_t        mon_e, mon_e_ovf;
  logic [7:0] bq[$];

  always #5 i_clock = ~i_clock;

  program_loader dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_rx_data       (rx_data),
    .i_rx_valid      (rx_valid),
    .i_cpu_halt      (cpu_halt),
    .o_instrmem_addr (mem_addr),
    .o_instrmem_data (mem_data),
    .o_instrmem_we   (mem_we),
    .o_cpu_valid     (cpu_valid),
    .o_cpu_reset     (cpu_reset),
    .o_load_done     (load_done),
    .o_run_done      (run_done),
    .o_overflow      (overflow),
    .o_word_count    (word_count)
  );

  program_loader #(.N_ADDR(4)) dut_ovf (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_rx_data       (rx_data_ovf),
    .i_rx_valid      (rx_valid_ovf),
    .i_cpu_halt      (cpu_halt_ovf),
    .o_instrmem_addr (mem_addr_ovf),
    .o_instrmem_data (mem_data_ovf),
    .o_instrmem_we   (mem_we_ovf),
    .o_cpu_valid     (cpu_valid_ovf),
    .o_cpu_reset     (cpu_reset_ovf),
    .o_load_done     (load_done_ovf),
    .o_run_done      (run_done_ovf),
    .o_overflow      (overflow_ovf),
    .o_word_count    (word_count_ovf)
  );

  // Write monitor and event counters for the main instance.
  always @(negedge i_clock) begin
    if (i_reset === 1'b1) begin
      if (mem_we !== 4'h0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL write: unexpected we=%h addr=%h data=%h", mem_we, mem_addr, mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (mem_we !== 4'hF || mem_addr !== mon_e.addr || mem_data !== mon_e.data) begin
            n_err++;
            $display("FAIL write: got we=%h addr=%h data=%h, expected we=f addr=%h data=%h",
                     mem_we, mem_addr, mem_data, mon_e.addr, mon_e.data);
          end
        end
      end
      if (load_done === 1'b1) load_done_cnt++;
      if (run_done === 1'b1) run_done_cnt++;
      if (cpu_valid === 1'b1) valid_cnt++;
    end
  end

  // Write monitor for the overflow instance.
  always @(negedge i_clock) begin
    if (i_reset === 1'b1) begin
      if (mem_we_ovf !== 4'h0) begin
        n_vec++;
        if (exp_ovf_q.size() == 0) begin
          n_err++;
          $display("FAIL write_ovf: unexpected we=%h addr=%h data=%h", mem_we_ovf, mem_addr_ovf, mem_data_ovf);
        end else begin
          mon_e_ovf = exp_ovf_q.pop_front();
          if (mem_we_ovf !== 4'hF || mem_addr_ovf !== mon_e_ovf.addr || mem_data_ovf !== mon_e_ovf.data) begin
            n_err++;
            $display("FAIL write_ovf: got we=%h addr=%h data=%h, expected we=f addr=%h data=%h",
                     mem_we_ovf, mem_addr_ovf, mem_data_ovf, mon_e_ovf.addr, mon_e_ovf.data);
          end
        end
      end
      if (load_done_ovf === 1'b1) load_done_ovf_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send(input bit ovf, input logic [7:0] b);
    if (ovf) begin
      rx_data_ovf  = b;
      rx_valid_ovf = 1'b1;
    end else begin
      rx_data  = b;
      rx_valid = 1'b1;
    end
    tick();
    rx_valid     = 1'b0;
    rx_valid_ovf = 1'b0;
  endtask

  task automatic send_q(input bit ovf, input bit gap);
    while (bq.size() > 0) begin
      send(ovf, bq.pop_front());
      if (gap) tick();
    end
  endtask

  initial begin
    i_reset = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; cpu_halt = 1'b0;
    rx_data_ovf = 8'h00; rx_valid_ovf = 1'b0; cpu_halt_ovf = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_we", mem_we, 4'h0);
    check("rst_cpu_valid", cpu_valid, 1'b0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_load_done", load_done, 1'b0);
    check("rst_run_done", run_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_addr", mem_addr, 16'h0);
    check("rst_data", mem_data, 32'h0);
    check("rst_word_count", word_count, 16'h0);
    i_reset = 1'b1;
    tick();
    check("cpu_reset_release", cpu_reset, 1'b0);

    // Basic load ending with HALT
    exp_q.push_back(wr_t'{16'h0000, 32'h1234_5678});
    exp_q.push_back(wr_t'{16'h0001, 32'hFFFF_FFFF});
    ld0 = load_done_cnt;
    send(1'b0, 8'h4C);
    tick();
    check("load_cpu_reset", cpu_reset, 1'b1);
    bq = {8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_q(1'b0, 1'b1);
    repeat (3) tick();
    check("load_done_pulses", load_done_cnt - ld0, 1);
    check("load_word_count", word_count, 16'd2);
    check("load_cpu_reset_after", cpu_reset, 1'b0);
    check("load_overflow", overflow, 1'b0);

    // Back-to-back bytes; 5th data byte lands in the first write cycle
    exp_q.push_back(wr_t'{16'h0000, 32'h4433_2211});
    exp_q.push_back(wr_t'{16'h0001, 32'h8877_6655});
    exp_q.push_back(wr_t'{16'h0002, 32'hFFFF_FFFF});
    ld0 = load_done_cnt;
    bq = {8'h4C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
          8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_q(1'b0, 1'b0);
    repeat (3) tick();
    check("b2b_load_done", load_done_cnt - ld0, 1);
    check("b2b_word_count", word_count, 16'd3);

    // Run for 10 cycles, then halt; a load command during RUN is ignored
    v0 = valid_cnt; rd0 = run_done_cnt;
    send(1'b0, 8'h52);
    repeat (4) tick();
    send(1'b0, 8'h4C);
    repeat (5) tick();
    cpu_halt = 1'b1;
    #1;
    check("run_halt_valid", cpu_valid, 1'b0);
    check("run_halt_done", run_done, 1'b1);
    tick();
    cpu_halt = 1'b0;
    repeat (4) tick();
    check("run_valid_cycles", valid_cnt - v0, 10);
    check("run_done_pulses", run_done_cnt - rd0, 1);
    check("run_idle_valid", cpu_valid, 1'b0);
    check("run_cpu_reset", cpu_reset, 1'b0);
    check("run_word_count_held", word_count, 16'd3);

`ifdef PROGRAM_LOADER_STEP_EN
    // Three single steps, then free run, then a halt that collides with a step strobe
    v0 = valid_cnt; rd0 = run_done_cnt;
    repeat (3) begin
      send(1'b0, 8'h53);
      tick();
    end
    tick();
    check("step_pulses", valid_cnt - v0, 3);
    send(1'b0, 8'h52);
    repeat (5) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    tick();
    check("step_run_valid", valid_cnt - v0, 8);
    check("step_run_done", run_done_cnt - rd0, 1);
    send(1'b0, 8'h53);
    tick();
    rx_data = 8'h53; rx_valid = 1'b1; cpu_halt = 1'b1;
    tick();
    rx_valid = 1'b0; cpu_halt = 1'b0;
    repeat (3) tick();
    check("step_halt_wins_valid", valid_cnt - v0, 9);
    check("step_halt_wins_done", run_done_cnt - rd0, 2);
    check("step_idle_valid", cpu_valid, 1'b0);
`else
    // Without step support 0x53 is ignored in IDLE
    v0 = valid_cnt; rd0 = run_done_cnt;
    repeat (3) begin
      send(1'b0, 8'h53);
      tick();
    end
    repeat (3) tick();
    check("nostep_valid", valid_cnt - v0, 0);
    check("nostep_run_done", run_done_cnt - rd0, 0);
`endif

    // Overflow with N_ADDR=4: five non-HALT words, only four written
    exp_ovf_q.push_back(wr_t'{16'h0000, 32'h0403_0201});
    exp_ovf_q.push_back(wr_t'{16'h0001, 32'h0403_0202});
    exp_ovf_q.push_back(wr_t'{16'h0002, 32'h0403_0203});
    exp_ovf_q.push_back(wr_t'{16'h0003, 32'h0403_0204});
    ld0 = load_done_ovf_cnt;
    bq = {8'h4C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02, 8'h02, 8'h03, 8'h04,
          8'h03, 8'h02, 8'h03, 8'h04, 8'h04, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h02, 8'h03, 8'h04};
    send_q(1'b1, 1'b1);
    repeat (3) tick();
    check("ovf_flag", overflow_ovf, 1'b1);
    check("ovf_load_done", load_done_ovf_cnt - ld0, 1);
    check("ovf_word_count", word_count_ovf, 16'd4);
    check("ovf_cpu_reset", cpu_reset_ovf, 1'b0);

    // Reset in the middle of a load discards the partial word
    bq = {8'h4C, 8'hAA, 8'hBB};
    send_q(1'b0, 1'b1);
    i_reset = 1'b0;
    #3;
    check("midrst_we", mem_we, 4'h0);
    check("midrst_word_count", word_count, 16'h0);
    check("midrst_cpu_reset", cpu_reset, 1'b1);
    check("midrst_data", mem_data, 32'h0);
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    exp_q.push_back(wr_t'{16'h0000, 32'hEFBE_ADDE});
    exp_q.push_back(wr_t'{16'h0001, 32'hFFFF_FFFF});
    bq = {8'h4C, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_q(1'b0, 1'b1);
    repeat (3) tick();
    check("midrst_reload_count", word_count, 16'd2);

    check("writes_outstanding", exp_q.size(), 0);
    check("writes_outstanding_ovf", exp_ovf_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
